// File: rtl/alu_pipe_if.sv
// Handshake and data bundle between the ALU pipe and its producer/consumer.
// The master is the datapath side. It presents operations and consumes results.
interface alu_pipe_if #(
    parameter int WIDTH    = 16,
    parameter int IMM_BITS = 5
);
    logic                in_valid;
    logic                in_ready;
    logic [2:0]          op;
    logic                imm_en;
    logic [IMM_BITS-1:0] imm;
    logic [WIDTH-1:0]    Ra;
    logic [WIDTH-1:0]    Rb;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    result;
    logic                flag_n;
    logic                flag_z;
    logic                flag_p;
    logic                flag_c;
    logic                flag_v;

    modport master (
        output in_valid, op, imm_en, imm, Ra, Rb, out_ready,
        input  in_ready, out_valid, result, flag_n, flag_z, flag_p, flag_c, flag_v
    );

    modport slave (
        input  in_valid, op, imm_en, imm, Ra, Rb, out_ready,
        output in_ready, out_valid, result, flag_n, flag_z, flag_p, flag_c, flag_v
    );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU stage between register-file read and writeback.
// Non-shift ops complete in one cycle.
// SLL by k>0 iterates one bit per cycle in a working register.
// A one-deep result register with valid/ready sits on the output.
// The NZP/C/V flags are loaded on the same edge as the result.
module alu_pipe #(
    parameter int WIDTH    = 16,
    parameter int IMM_BITS = 5,
    parameter int SH_BITS  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_pipe_if.slave   bus
);
    localparam logic [2:0] OP_PASSA = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_NOT   = 3'd3;
    localparam logic [2:0] OP_SUB   = 3'd4;
    localparam logic [2:0] OP_OR    = 3'd5;
    localparam logic [2:0] OP_XOR   = 3'd6;
    localparam logic [2:0] OP_SLL   = 3'd7;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               out_valid_q, out_valid_d;
    logic               flag_n_q, flag_n_d;
    logic               flag_z_q, flag_z_d;
    logic               flag_p_q, flag_p_d;
    logic               flag_c_q, flag_c_d;
    logic               flag_v_q, flag_v_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SH_BITS-1:0] cnt_q, cnt_d;

    logic               in_xfer, out_xfer;
    logic [WIDTH-1:0]   opb, b_eff, alu_val, load_val;
    logic [WIDTH:0]     sum_full;
    logic               is_sub, is_arith, add_v, load;
    logic [SH_BITS-1:0] sh_amt;

    assign bus.in_ready  = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign in_xfer       = bus.in_valid && bus.in_ready;
    assign out_xfer      = out_valid_q && bus.out_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flag_n    = flag_n_q;
    assign bus.flag_z    = flag_z_q;
    assign bus.flag_p    = flag_p_q;
    assign bus.flag_c    = flag_c_q;
    assign bus.flag_v    = flag_v_q;

    // Operand B selection and the shared adder. SUB is Ra + ~B + 1, so C=1 means no borrow.
    always_comb begin
        opb      = bus.imm_en ? {{(WIDTH-IMM_BITS){bus.imm[IMM_BITS-1]}}, bus.imm} : bus.Rb;
        sh_amt   = opb[SH_BITS-1:0];
        is_sub   = (bus.op == OP_SUB);
        is_arith = is_sub || (bus.op == OP_ADD);
        b_eff    = is_sub ? ~opb : opb;
        sum_full = {1'b0, bus.Ra} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        add_v    = (bus.Ra[WIDTH-1] == b_eff[WIDTH-1]) &&
                   (sum_full[WIDTH-1] != bus.Ra[WIDTH-1]);
    end

    // Single-cycle function select. An SLL that reaches here has amount 0, so it passes Ra.
    always_comb begin
        alu_val = '0;
        case (bus.op)
            OP_PASSA: alu_val = bus.Ra;
            OP_ADD:   alu_val = sum_full[WIDTH-1:0];
            OP_AND:   alu_val = bus.Ra & opb;
            OP_NOT:   alu_val = ~bus.Ra;
            OP_SUB:   alu_val = sum_full[WIDTH-1:0];
            OP_OR:    alu_val = bus.Ra | opb;
            OP_XOR:   alu_val = bus.Ra ^ opb;
            OP_SLL:   alu_val = bus.Ra;
            default:  alu_val = '0;
        endcase
    end

    // Next-state logic: IDLE/SHIFT control, the output register, and the flag update on each load.
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        flag_n_d    = flag_n_q;
        flag_z_d    = flag_z_q;
        flag_p_d    = flag_p_q;
        flag_c_d    = flag_c_q;
        flag_v_d    = flag_v_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        load        = 1'b0;
        load_val    = '0;

        case (state_q)
            IDLE: begin
                if (out_xfer) out_valid_d = 1'b0;
                if (in_xfer) begin
                    if (bus.op == OP_SLL && sh_amt != '0) begin
                        work_d      = bus.Ra;
                        cnt_d       = sh_amt;
                        out_valid_d = 1'b0;
                        state_d     = SHIFT;
                    end else begin
                        load     = 1'b1;
                        load_val = alu_val;
                        if (is_arith) begin
                            flag_c_d = sum_full[WIDTH];
                            flag_v_d = add_v;
                        end
                    end
                end
            end
            SHIFT: begin
                // The last step writes its shifted value straight into the result register.
                work_d = work_q << 1;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == {{(SH_BITS-1){1'b0}}, 1'b1}) begin
                    load     = 1'b1;
                    load_val = work_q << 1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            result_d    = load_val;
            out_valid_d = 1'b1;
            flag_n_d    = load_val[WIDTH-1];
            flag_z_d    = (load_val == '0);
            flag_p_d    = !load_val[WIDTH-1] && (load_val != '0);
        end
    end

    // State and datapath registers. Reset drops any shift in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            flag_n_q    <= 1'b0;
            flag_z_q    <= 1'b1;
            flag_p_q    <= 1'b0;
            flag_c_q    <= 1'b0;
            flag_v_q    <= 1'b0;
            work_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            flag_n_q    <= flag_n_d;
            flag_z_q    <= flag_z_d;
            flag_p_q    <= flag_p_d;
            flag_c_q    <= flag_c_d;
            flag_v_q    <= flag_v_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe.
// A table of vectors runs back-to-back through a scoreboard queue.
// Hand-written sequences then cover shift latency, backpressure and reset during a shift.
module tb_alu_pipe;
    localparam logic [2:0] OP_PASSA = 3'd0, OP_ADD = 3'd1, OP_AND = 3'd2, OP_NOT = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4, OP_OR = 3'd5, OP_XOR = 3'd6, OP_SLL = 3'd7;

    typedef struct {
        logic [2:0]  op;
        logic        ie;
        logic [4:0]  im;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        n, z, p, c, v;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic [2:0]  nzp;
        logic [1:0]  cv;
        logic        care_cv;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[16];

    alu_pipe_if #(.WIDTH(16), .IMM_BITS(5)) bus();

    alu_pipe #(.WIDTH(16), .IMM_BITS(5), .SH_BITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] r, input logic [2:0] nzp,
                                input logic [1:0] cv, input logic care);
        exp_t e;
        e.res = r; e.nzp = nzp; e.cv = cv; e.care_cv = care;
        return e;
    endfunction

    // Consumer side: every output transfer is checked against the head of the queue.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_output: got %h, expected no output", bus.result);
            end else begin
                mon_e = sb.pop_front();
                chk("result", {16'h0, bus.result}, {16'h0, mon_e.res});
                chk("nzp", {29'h0, bus.flag_n, bus.flag_z, bus.flag_p}, {29'h0, mon_e.nzp});
                if (mon_e.care_cv)
                    chk("cv", {30'h0, bus.flag_c, bus.flag_v}, {30'h0, mon_e.cv});
            end
        end
    end

    // Called just after a rising edge. Returns just after the edge that accepted the op.
    task automatic send(input logic [2:0] op, input logic ie, input logic [4:0] im,
                        input logic [15:0] a, input logic [15:0] b, input exp_t e);
        int g = 0;
        bus.in_valid = 1'b1; bus.op = op; bus.imm_en = ie; bus.imm = im;
        bus.Ra = a; bus.Rb = b;
        @(negedge clk);
        while (!bus.in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!bus.in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
        end else begin
            sb.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("drain_pending", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Vector fields: op, imm_en, imm, Ra, Rb, expected result, then N, Z, P, C, V.
        tbl[0]  = '{OP_ADD,   1'b1, 5'h1f, 16'h0005, 16'h0000, 16'h0004, 0, 0, 1, 1, 0};
        tbl[1]  = '{OP_SUB,   1'b0, 5'h00, 16'h0003, 16'h0005, 16'hFFFE, 1, 0, 0, 0, 0};
        tbl[2]  = '{OP_ADD,   1'b0, 5'h00, 16'h7FFF, 16'h0001, 16'h8000, 1, 0, 0, 0, 1};
        tbl[3]  = '{OP_AND,   1'b0, 5'h00, 16'h00F0, 16'h0FF0, 16'h00F0, 0, 0, 1, 0, 1};
        tbl[4]  = '{OP_OR,    1'b0, 5'h00, 16'h00F0, 16'h0F0F, 16'h0FFF, 0, 0, 1, 0, 1};
        tbl[5]  = '{OP_XOR,   1'b0, 5'h00, 16'h00FF, 16'h00FF, 16'h0000, 0, 1, 0, 0, 1};
        tbl[6]  = '{OP_NOT,   1'b0, 5'h00, 16'h0000, 16'h1234, 16'hFFFF, 1, 0, 0, 0, 1};
        tbl[7]  = '{OP_PASSA, 1'b0, 5'h00, 16'h1234, 16'hFFFF, 16'h1234, 0, 0, 1, 0, 1};
        tbl[8]  = '{OP_SUB,   1'b0, 5'h00, 16'h0005, 16'h0005, 16'h0000, 0, 1, 0, 1, 0};
        tbl[9]  = '{OP_SUB,   1'b0, 5'h00, 16'h8000, 16'h0001, 16'h7FFF, 0, 0, 1, 1, 1};
        tbl[10] = '{OP_SLL,   1'b0, 5'h00, 16'hABCD, 16'h0010, 16'hABCD, 1, 0, 0, 1, 1};
        tbl[11] = '{OP_ADD,   1'b1, 5'h10, 16'h0000, 16'h0000, 16'hFFF0, 1, 0, 0, 0, 0};
        tbl[12] = '{OP_ADD,   1'b0, 5'h00, 16'hFFFF, 16'h0001, 16'h0000, 0, 1, 0, 1, 0};
        tbl[13] = '{OP_SLL,   1'b0, 5'h00, 16'h0003, 16'h0002, 16'h000C, 0, 0, 1, 1, 0};
        tbl[14] = '{OP_ADD,   1'b0, 5'h00, 16'h8000, 16'h8000, 16'h0000, 0, 1, 0, 1, 1};
        tbl[15] = '{OP_SLL,   1'b1, 5'h0F, 16'h8001, 16'h0000, 16'h8000, 1, 0, 0, 1, 1};

        bus.in_valid = 0; bus.op = 0; bus.imm_en = 0; bus.imm = 0;
        bus.Ra = 0; bus.Rb = 0; bus.out_ready = 1;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // Reset state.
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_nzpcv", {bus.flag_n, bus.flag_z, bus.flag_p, bus.flag_c, bus.flag_v}, 5'b01000);
        chk("rst_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;

        // Table vectors, back-to-back.
        for (int i = 0; i < 16; i++)
            send(tbl[i].op, tbl[i].ie, tbl[i].im, tbl[i].a, tbl[i].b,
                 mk(tbl[i].res, {tbl[i].n, tbl[i].z, tbl[i].p}, {tbl[i].c, tbl[i].v}, 1'b1));
        bus.in_valid = 0;
        drain();

        // SLL by 4: busy for 4 cycles, result in the 5th.
        bus.in_valid = 1; bus.op = OP_SLL; bus.imm_en = 0; bus.Ra = 16'h0001; bus.Rb = 16'h0004;
        @(negedge clk);
        chk("sll4_accept_ready", bus.in_ready, 1);
        sb.push_back(mk(16'h0010, 3'b001, 2'b00, 1'b0));
        @(posedge clk); #1 bus.in_valid = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("sll4_busy", {bus.in_ready, bus.out_valid}, 2'b00);
        end
        @(negedge clk);
        chk("sll4_valid", bus.out_valid, 1);
        chk("sll4_result", bus.result, 16'h0010);
        @(posedge clk); #1;

        // SLL by 0 behaves as a single-cycle op.
        bus.in_valid = 1; bus.op = OP_SLL; bus.Ra = 16'h1234; bus.Rb = 16'h0020;
        @(negedge clk);
        chk("sll0_accept_ready", bus.in_ready, 1);
        sb.push_back(mk(16'h1234, 3'b001, 2'b00, 1'b0));
        @(posedge clk); #1 bus.in_valid = 0;
        @(negedge clk);
        chk("sll0_valid", bus.out_valid, 1);
        chk("sll0_result", bus.result, 16'h1234);
        @(posedge clk); #1;

        // Backpressure: the AND result is held and the OR waits.
        bus.out_ready = 0;
        send(OP_AND, 1'b0, 5'h0, 16'h00F0, 16'h0FF0, mk(16'h00F0, 3'b001, 2'b00, 1'b0));
        bus.op = OP_OR; bus.Ra = 16'h00F0; bus.Rb = 16'h0F0F;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_result_hold", bus.result, 16'h00F0);
            chk("bp_flags_hold", {bus.flag_n, bus.flag_z, bus.flag_p}, 3'b001);
        end
        @(posedge clk); #1 bus.out_ready = 1;
        @(negedge clk);
        chk("bp_release_ready", bus.in_ready, 1);
        sb.push_back(mk(16'h0FFF, 3'b001, 2'b00, 1'b0));
        @(posedge clk); #1 bus.in_valid = 0;
        @(negedge clk);
        chk("bp_or_valid", bus.out_valid, 1);
        chk("bp_or_result", bus.result, 16'h0FFF);
        @(posedge clk); #1;

        // Reset during SHIFT: the shift result must never appear.
        bus.in_valid = 1; bus.op = OP_SLL; bus.Ra = 16'h0003; bus.Rb = 16'h0008;
        @(negedge clk);
        chk("rs_accept_ready", bus.in_ready, 1);
        @(posedge clk); #1 bus.in_valid = 0;
        @(posedge clk);
        @(posedge clk); #1 rst_n = 0;
        @(negedge clk);
        chk("rs_in_reset_valid", bus.out_valid, 0);
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        chk("rs_out_valid", bus.out_valid, 0);
        chk("rs_result", bus.result, 0);
        chk("rs_flag_z", bus.flag_z, 1);
        chk("rs_in_ready", bus.in_ready, 1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("rs_no_output", bus.out_valid, 0);
        end
        @(posedge clk); #1;

        // Normal operation resumes after reset.
        send(OP_ADD, 1'b0, 5'h0, 16'h0001, 16'h0001, mk(16'h0002, 3'b001, 2'b00, 1'b1));
        bus.in_valid = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
